// File: rtl/pt_rf_arbiter.sv
// pt_rf_arbiter: round-robin arbiter sharing one single-port register file
// between N_REQ requesters. Each requester has a one-entry response slot.
// Build option: define PT_RF_ARB_PRIO0_EN to give requester 0 absolute priority
// over the round-robin among the remaining requesters.
module pt_rf_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  output logic                      o_idle,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_req_wdata,
  input  logic [N_REQ-1:0]          i_req_write,
  output logic [N_REQ-1:0]          o_rsp_valid,
  input  logic [N_REQ-1:0]          i_rsp_ready,
  output logic [N_REQ*DATA_W-1:0]   o_rsp_data,
  output logic [N_REQ-1:0]          o_rsp_error,
  output logic [ADDR_W-1:0]         o_rf_address,
  output logic [DATA_W-1:0]         o_rf_wr_data,
  output logic                      o_rf_write,
  output logic                      o_rf_enable,
  input  logic [DATA_W-1:0]         i_rf_rd_data,
  input  logic                      i_rf_error
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]         rr_q, rr_d;
  logic                    pend_q, pend_d;
  logic [ID_W-1:0]         pend_id_q, pend_id_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [N_REQ*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [N_REQ-1:0]        rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0]        elig;
  logic [N_REQ-1:0]        rr_elig;
  logic [N_REQ-1:0]        gnt;
  logic                    gnt_any;
  logic [ID_W-1:0]         gnt_id;
  logic                    rr_upd;
  int                      idx;

  // A requester may be granted only if its slot will be free and it has no access in flight
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = i_rst_n && i_req_valid[i] &&
                (!rsp_valid_q[i] || i_rsp_ready[i]) &&
                !(pend_q && (int'(pend_id_q) == i));
    end
  end

  // Pick the first eligible requester after the last one granted, optionally letting requester 0 pre-empt
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    rr_elig = elig;
`ifdef PT_RF_ARB_PRIO0_EN
    rr_elig[0] = 1'b0;
`endif
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_q) + k) % N_REQ;
      if (!gnt_any && rr_elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
`ifdef PT_RF_ARB_PRIO0_EN
    if (elig[0]) begin
      gnt_any = 1'b1;
      gnt_id  = '0;
    end
    rr_upd = gnt_any && (gnt_id != '0);
`else
    rr_upd = gnt_any;
`endif
  end

  // Drive the one-hot grant and the downstream access from the granted slice
  always_comb begin
    gnt          = '0;
    o_rf_enable  = 1'b0;
    o_rf_write   = 1'b0;
    o_rf_address = '0;
    o_rf_wr_data = '0;
    if (gnt_any) begin
      gnt[gnt_id]  = 1'b1;
      o_rf_enable  = 1'b1;
      o_rf_write   = i_req_write[gnt_id];
      o_rf_address = i_req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
      o_rf_wr_data = i_req_wdata[int'(gnt_id)*DATA_W +: DATA_W];
    end
  end

  // Next state: remember the grant, drain consumed slots, load the slot of last cycle's access
  always_comb begin
    rr_d        = rr_q;
    pend_d      = gnt_any;
    pend_id_d   = gnt_id;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    if (rr_upd) begin
      rr_d = gnt_id;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (rsp_valid_q[i] && i_rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
      if (pend_q && (int'(pend_id_q) == i)) begin
        rsp_valid_d[i]                 = 1'b1;
        rsp_data_d[i*DATA_W +: DATA_W] = i_rf_rd_data;
        rsp_err_d[i]                   = i_rf_error;
      end
    end
  end

  // State registers; reset discards anything in flight or buffered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q        <= ID_W'(N_REQ - 1);
      pend_q      <= 1'b0;
      pend_id_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      pend_q      <= pend_d;
      pend_id_q   <= pend_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = gnt;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_error = rsp_err_q;
  assign o_idle      = !i_rst_n || (!(|i_req_valid) && !pend_q && !(|rsp_valid_q));

`ifndef SYNTHESIS
  // The slot receiving a response must already be empty, so load and drain never collide
  a_no_slot_overwrite: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    pend_q |-> !rsp_valid_q[pend_id_q]);
`endif

endmodule

// File: tb/tb_pt_rf_arbiter.sv
// tb_pt_rf_arbiter: table-driven arbitration vectors with a response scoreboard
// for pt_rf_arbiter (N_REQ=2, default build).
module tb_pt_rf_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n = 1'b0;
  logic                    o_idle;
  logic [N_REQ-1:0]        i_req_valid = '0;
  logic [N_REQ-1:0]        o_req_ready;
  logic [N_REQ*ADDR_W-1:0] i_req_addr = '0;
  logic [N_REQ*DATA_W-1:0] i_req_wdata = '0;
  logic [N_REQ-1:0]        i_req_write = '0;
  logic [N_REQ-1:0]        o_rsp_valid;
  logic [N_REQ-1:0]        i_rsp_ready = '0;
  logic [N_REQ*DATA_W-1:0] o_rsp_data;
  logic [N_REQ-1:0]        o_rsp_error;
  logic [ADDR_W-1:0]       o_rf_address;
  logic [DATA_W-1:0]       o_rf_wr_data;
  logic                    o_rf_write;
  logic                    o_rf_enable;
  logic [DATA_W-1:0]       i_rf_rd_data;
  logic                    i_rf_error;

  pt_rf_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_idle(o_idle),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_write(i_req_write),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_error(o_rsp_error),
    .o_rf_address(o_rf_address), .o_rf_wr_data(o_rf_wr_data),
    .o_rf_write(o_rf_write), .o_rf_enable(o_rf_enable),
    .i_rf_rd_data(i_rf_rd_data), .i_rf_error(i_rf_error)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Register-file model: data is {~addr, addr}, error when address bit 4 is set
  logic              rf_en_q;
  logic [ADDR_W-1:0] rf_addr_q;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
    end else begin
      rf_en_q   <= o_rf_enable;
      rf_addr_q <= o_rf_address;
    end
  end
  assign i_rf_rd_data = rf_en_q ? {~rf_addr_q, rf_addr_q} : '0;
  assign i_rf_error   = rf_en_q & rf_addr_q[4];

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [1:0]  rdy;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  exp_ready;
    bit          chk_idle;
    bit          exp_idle;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic        err;
    bit          wr;
    int          gcyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] cur_a0 = '0;
  logic [31:0] cur_a1 = '0;
  logic [63:0] cur_d0 = 64'h1111;
  logic [63:0] cur_d1 = 64'h2222;

  function automatic vec_t mkVec(logic [1:0] valid, logic [1:0] write, logic [1:0] rdy,
                                 logic [1:0] exp_ready, bit chk_idle, bit exp_idle);
    vec_t v;
    v.valid = valid; v.write = write; v.rdy = rdy;
    v.a0 = cur_a0; v.a1 = cur_a1; v.d0 = cur_d0; v.d1 = cur_d1;
    v.exp_ready = exp_ready; v.chk_idle = chk_idle; v.exp_idle = exp_idle;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare each response slot against the scoreboard and retire consumed responses
  task automatic checkResponses();
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      bit exp_valid;
      k = -1;
      exp_valid = 1'b0;
      for (int j = 0; j < sb.size(); j++) begin
        if (k < 0 && sb[j].id == i) k = j;
      end
      if (k >= 0) begin
        if (cyc >= sb[k].gcyc + 2) exp_valid = 1'b1;
      end
      checkOutput($sformatf("rsp_valid[%0d]", i), 64'(o_rsp_valid[i]), 64'(exp_valid));
      if (exp_valid && o_rsp_valid[i] && i_rsp_ready[i]) begin
        checkOutput($sformatf("rsp_error[%0d]", i), 64'(o_rsp_error[i]), 64'(sb[k].err));
        if (!sb[k].wr) begin
          checkOutput($sformatf("rsp_data[%0d]", i), o_rsp_data[i*DATA_W +: DATA_W], sb[k].data);
        end
        sb.delete(k);
      end
    end
  endtask

  // Drive one cycle of inputs, check grant/issue outputs, and record the expected response
  task automatic applyStimulus(vec_t v);
    int          id;
    logic [31:0] a;
    logic [63:0] d;
    exp_t        e;
    @(negedge i_clk);
    i_req_valid = v.valid;
    i_req_write = v.write;
    i_rsp_ready = v.rdy;
    i_req_addr  = {v.a1, v.a0};
    i_req_wdata = {v.d1, v.d0};
    #1;
    checkOutput("req_ready", 64'(o_req_ready), 64'(v.exp_ready));
    checkOutput("rf_enable", 64'(o_rf_enable), 64'(|v.exp_ready));
    if (v.chk_idle) checkOutput("idle", 64'(o_idle), 64'(v.exp_idle));
    checkResponses();
    if (v.exp_ready != 2'b00) begin
      id = v.exp_ready[1] ? 1 : 0;
      a  = (id == 1) ? v.a1 : v.a0;
      d  = (id == 1) ? v.d1 : v.d0;
      checkOutput("rf_address", 64'(o_rf_address), 64'(a));
      checkOutput("rf_wr_data", o_rf_wr_data, d);
      checkOutput("rf_write", 64'(o_rf_write), 64'(v.write[id]));
      e.id = id; e.data = {~a, a}; e.err = a[4]; e.wr = v.write[id]; e.gcyc = cyc;
      sb.push_back(e);
    end else begin
      checkOutput("rf_address_idle", 64'(o_rf_address), 64'h0);
    end
  endtask

  // Checks made while reset is held low
  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_req_ready"}, 64'(o_req_ready), 64'h0);
    checkOutput({tag, "_idle"}, 64'(o_idle), 64'h1);
    checkOutput({tag, "_rf_enable"}, 64'(o_rf_enable), 64'h0);
    checkOutput({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'h0);
  endtask

  initial begin
    // Both requesters streaming reads: strict alternation starting at requester 0
    cur_a0 = 32'h200; cur_a1 = 32'h300;
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b11, 2'b01, 1, 0));
    for (int r = 0; r < 5; r++) begin
      vecs.push_back(mkVec(2'b11, 2'b00, 2'b11, (r % 2 == 0) ? 2'b10 : 2'b01, 0, 0));
    end
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 0, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 0, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 1, 1));
    // Requester 1 write to 0x10 returning an error
    cur_a1 = 32'h10; cur_d1 = 64'hDEAD;
    vecs.push_back(mkVec(2'b10, 2'b10, 2'b11, 2'b10, 0, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 0, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 1, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 1, 1));
    // Requester 0 slot full and not consumed: only requester 1 proceeds
    cur_a0 = 32'h400; cur_a1 = 32'h500; cur_d1 = 64'h2222;
    vecs.push_back(mkVec(2'b01, 2'b00, 2'b10, 2'b01, 0, 0));
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b10, 2'b10, 0, 0));
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b10, 2'b10, 0, 0));
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b10, 2'b00, 0, 0));
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b10, 2'b10, 0, 0));
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b11, 2'b01, 0, 0));
    vecs.push_back(mkVec(2'b11, 2'b00, 2'b11, 2'b10, 0, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 0, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 0, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 1, 1));
    // Single requester streaming: granted every other cycle
    cur_a0 = 32'h600;
    for (int r = 0; r < 6; r++) begin
      vecs.push_back(mkVec(2'b01, 2'b00, 2'b11, (r % 2 == 0) ? 2'b01 : 2'b00, 0, 0));
    end
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 1, 0));
    vecs.push_back(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 1, 1));

    // Reset with requests already asserted: nothing may be granted
    i_req_valid = 2'b11;
    i_rsp_ready = 2'b11;
    #1;
    checkResetOutputs("reset");
    @(negedge i_clk);
    checkResetOutputs("reset_hold");
    i_rst_n     = 1'b1;
    i_req_valid = 2'b00;

    foreach (vecs[n]) applyStimulus(vecs[n]);

    // Reset one cycle after a grant: the in-flight response must vanish
    cur_a0 = 32'h700; cur_a1 = 32'h800;
    applyStimulus(mkVec(2'b01, 2'b00, 2'b11, 2'b01, 0, 0));
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_req_valid = 2'b11;
    sb.delete();
    #1;
    checkResetOutputs("midrst");
    @(negedge i_clk);
    #1;
    checkResetOutputs("midrst_hold");
    @(negedge i_clk);
    i_rst_n     = 1'b1;
    i_req_valid = 2'b00;
    #1;
    checkOutput("post_reset_idle", 64'(o_idle), 64'h1);
    checkResponses();
    applyStimulus(mkVec(2'b11, 2'b00, 2'b11, 2'b01, 0, 0));
    applyStimulus(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 0, 0));
    applyStimulus(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 0, 0));
    applyStimulus(mkVec(2'b00, 2'b00, 2'b11, 2'b00, 1, 1));

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
